// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Front-end controller for the 6-bit signed ALU test block. The user sets the
// switches and presses enter three times (operand A, operand B, opcode). The
// block then holds the ALU inputs steady for SETTLE_CYCLES clocks so the purely
// combinational ALU can settle. It registers the ALU result, raises valid_o,
// and waits for one more press before it accepts a new operand set.
//
// Parameters
//   SETTLE_CYCLES  EXEC cycles between opcode load and result capture (>=1)
//   SYNC_STAGES    flops in the enter_i synchronizer (>=1)
//
// Optional feature (compile-time macro ALU_SEQ_DIVZERO_EN)
//   Defined   : a divide (Op_o==2'b11) with B_o==0 captures 12'h000 and raises
//               err_o instead of copying the ALU output.
//   Undefined : err_o is tied 0 and data_i is always captured as-is.
//
// Ports
//   clk_i     in   1   system clock, rising edge
//   rst_n_i   in   1   asynchronous active-low reset
//   sw_i      in   6   switch value: signed operand, or opcode in sw_i[1:0]
//   enter_i   in   1   debounced enter button (level); each rising edge = press
//   show_i    in   1   request operand echo on the ALU (forwarded to Led_o)
//   A_o       out  6   ALU operand A
//   B_o       out  6   ALU operand B
//   Op_o      out  2   ALU opcode (00 add, 01 sub, 10 mul, 11 {rem,quo})
//   Led_o     out  1   ALU echo select, forced 0 while executing
//   data_i    in   12  ALU result
//   result_o  out  12  captured ALU result
//   valid_o   out  1   result_o belongs to the current operand set
//   err_o     out  1   divide-by-zero flag
//   state_o   out  3   current FSM state (debug LEDs)
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [5:0]  sw_i,
    input  logic        enter_i,
    input  logic        show_i,
    output logic [5:0]  A_o,
    output logic [5:0]  B_o,
    output logic [1:0]  Op_o,
    output logic        Led_o,
    input  logic [11:0] data_i,
    output logic [11:0] result_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    // State encoding is visible on the debug LEDs, so it is fixed.
    localparam logic [2:0] ST_ENTER_A  = 3'd0;
    localparam logic [2:0] ST_ENTER_B  = 3'd1;
    localparam logic [2:0] ST_ENTER_OP = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [1:0] OP_DIV = 2'b11;

    // The counter must hold SETTLE_CYCLES-1. Keep it at least one bit wide
    // so that SETTLE_CYCLES==1 still elaborates.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Enter synchronizer and rising-edge detector
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   press;

    // NOTE: clocked state uses non-blocking assignments only. Every flop then
    // samples the pre-edge value of its neighbour, and the chain shifts by one
    // stage per clock instead of collapsing into a single flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else begin
            sync_q[0] <= enter_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse per rising edge. A held button produces only one press.
    assign press = sync_q[SYNC_STAGES-1] & ~sync_d_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state_d gets a default before the case statement. Every path
    // therefore assigns it, and no latch is inferred for the branches that
    // leave the state unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTER_A:  if (press) state_d = ST_ENTER_B;
            ST_ENTER_B:  if (press) state_d = ST_ENTER_OP;
            ST_ENTER_OP: if (press) state_d = ST_EXEC;
            // Presses are not looked at here, so they are dropped rather than queued.
            ST_EXEC:     if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:     if (press) state_d = ST_ENTER_A;
            default:     state_d = ST_ENTER_A;   // recover from encodings 5-7
        endcase
    end

    // -------------------------------------------------------------------------
    // State, operand registers and result capture
    // -------------------------------------------------------------------------
    logic [5:0]  a_q;
    logic [5:0]  b_q;
    logic [1:0]  op_q;
    logic        led_q;
    logic [11:0] result_q;
    logic        valid_q;
`ifdef ALU_SEQ_DIVZERO_EN
    logic        err_q;
`endif

    // NOTE: every register here, including the captured result, is cleared by
    // the asynchronous reset. An aborted operation must never leave a partial
    // or stale result visible.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_ENTER_A;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            led_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            // Led_o is decoded from the next state, so it is already low during
            // the first EXEC cycle. Otherwise the capture could see the {A,B}
            // echo instead of the arithmetic result.
            led_q <= (state_d == ST_EXEC) ? 1'b0 : show_i;

            case (state_q)
                ST_ENTER_A: begin
                    if (press) a_q <= sw_i;
                end

                ST_ENTER_B: begin
                    if (press) b_q <= sw_i;
                end

                ST_ENTER_OP: begin
                    if (press) begin
                        op_q  <= sw_i[1:0];
                        cnt_q <= CNT_LOAD;
                    end
                end

                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        valid_q <= 1'b1;
`ifdef ALU_SEQ_DIVZERO_EN
                        if (op_q == OP_DIV && b_q == 6'd0) begin
                            result_q <= 12'h000;
                            err_q    <= 1'b1;
                        end else begin
                            result_q <= data_i;
                            err_q    <= 1'b0;
                        end
`else
                        // With B==0 the ALU output is undefined, and it is still
                        // copied unchanged.
                        result_q <= data_i;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // The result and operands stay visible until the next
                    // operand set overwrites them. Only the flags are cleared.
                    if (press) begin
                        valid_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
                        err_q   <= 1'b0;
`endif
                    end
                end

                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign A_o      = a_q;
    assign B_o      = b_q;
    assign Op_o     = op_q;
    assign Led_o    = led_q;
    assign result_o = result_q;
    assign valid_o  = valid_q;
    assign state_o  = state_q;
`ifdef ALU_SEQ_DIVZERO_EN
    assign err_o    = err_q;
`else
    assign err_o    = 1'b0;
`endif

endmodule
